// File: rtl/mix_col_seq.sv
// AES MixColumns, sequential: one shared column datapath applied
// to the four state columns on successive cycles.
module mix_col_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] wr_q, wr_d;
    logic [31:0]  col_in, col_out;
    logic [7:0]   s0, s1, s2, s3;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        col_in = wr_q[127:96];
        unique case (col_q)
            2'd0: col_in = wr_q[127:96];
            2'd1: col_in = wr_q[95:64];
            2'd2: col_in = wr_q[63:32];
            2'd3: col_in = wr_q[31:0];
        endcase
    end

    assign s0 = col_in[31:24];
    assign s1 = col_in[23:16];
    assign s2 = col_in[15:8];
    assign s3 = col_in[7:0];

    // 3b is written as xt(b) ^ b
    assign col_out[31:24] = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
    assign col_out[23:16] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
    assign col_out[15:8]  = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
    assign col_out[7:0]   = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        wr_d      = wr_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_state = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    wr_d    = in_state;
                    col_d   = 2'd0;
                    state_d = in_bypass ? DONE : RUN;
                end
            end
            RUN: begin
                unique case (col_q)
                    2'd0: wr_d[127:96] = col_out;
                    2'd1: wr_d[95:64]  = col_out;
                    2'd2: wr_d[63:32]  = col_out;
                    2'd3: wr_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_state = wr_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_mix_col_seq.sv
// Bench for mix_col_seq: cycle-level reference model plus
// directed vectors and randomized traffic.
module tb_mix_col_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    mix_col_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s,
                                             input logic byp);
        logic [7:0]   m [4][4];
        logic [7:0]   acc;
        logic [127:0] r;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1},
              '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3},
              '{8'd3, 8'd1, 8'd1, 8'd2}};
        if (byp) return s;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[row][k], s[127-32*c-8*k -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Reference model: one pending result, visible from ready_at on
    bit           chk_en  = 0;
    bit           pending = 0;
    int           cyc     = 0;
    int           ready_at = 0;
    logic [127:0] res     = '0;
    int           acc_q[$];
    int           hs_q[$];

    initial forever begin
        bit exp_v;
        @(negedge clk);
        exp_v = pending && (cyc >= ready_at);
        if (chk_en) begin
            chk("out_valid", 128'(out_valid), 128'(exp_v));
            chk("in_ready", 128'(in_ready),
                128'(!pending && !rst));
            chk("busy", 128'(busy), 128'(pending));
            chk("out_state", out_state, exp_v ? res : 128'h0);
        end
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) hs_q.push_back(cyc);
        if (rst) begin
            pending = 0;
            chk_en  = 1;
        end else if (exp_v && out_ready) begin
            pending = 0;
        end else if (!pending && in_valid) begin
            pending  = 1;
            res      = ref_mix(in_state, in_bypass);
            ready_at = cyc + 1 + (in_bypass ? 0 : 4);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_80808080;
    localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_80808080;
    localparam logic [127:0] VB = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int           n;
        logic [127:0] vec [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b0;

        chk("ref_v1", ref_mix(V1, 1'b0), R1);
        chk("ref_v2", ref_mix(V2, 1'b0), R2);
        chk("ref_byp", ref_mix(VB, 1'b1), VB);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 128'(in_ready), 128'h1);

        // mixed vector 1, out_ready held high
        tick();
        out_ready = 1'b1;
        in_state  = V1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = rnd128();
        wait_valid(n);
        chk("lat_mixed", 128'(n), 128'd4);
        chk("v1_result", out_state, R1);
        @(negedge clk);
        chk("v1_pulse", 128'(out_valid), 128'h0);

        // mixed vector 2
        tick();
        in_state = V2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk("lat_mixed2", 128'(n), 128'd4);
        chk("v2_result", out_state, R2);

        // bypass with stalled consumer
        tick();
        out_ready = 1'b0;
        in_bypass = 1'b1;
        in_state  = VB;
        in_valid  = 1'b1;
        tick();
        for (int k = 1; k < 10; k++) begin
            in_valid = 1'($urandom);
            in_state = rnd128();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("byp_valid", 128'(out_valid), 128'h1);
        chk("byp_state", out_state, VB);
        chk("byp_rdy", 128'(in_ready), 128'h0);
        tick();
        out_ready = 1'b0;
        in_bypass = 1'b0;
        @(negedge clk);
        chk("byp_rdy_after", 128'(in_ready), 128'h1);

        // reset in the middle of a mixed op
        tick();
        out_ready = 1'b1;
        in_state  = V1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'h0);
        chk("abort_valid", 128'(out_valid), 128'h0);
        chk("abort_state", out_state, 128'h0);
        tick();
        in_state = V2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk("post_abort_lat", 128'(n), 128'd4);
        chk("post_abort_res", out_state, R2);

        // back-to-back throughput
        tick();
        for (int i = 0; i < 3; i++) vec[i] = rnd128();
        acc_q.delete();
        hs_q.delete();
        in_state = vec[0];
        in_valid = 1'b1;
        for (int t = 0; t < 40 && hs_q.size() < 3; t++) begin
            tick();
            if (acc_q.size() >= 3) in_valid = 1'b0;
            else in_state = vec[acc_q.size()];
        end
        chk("b2b_accepts", 128'(acc_q.size()), 128'd3);
        chk("b2b_results", 128'(hs_q.size()), 128'd3);
        if (acc_q.size() == 3 && hs_q.size() == 3) begin
            chk("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'd6);
            chk("b2b_gap2", 128'(acc_q[2] - acc_q[1]), 128'd6);
            for (int i = 0; i < 3; i++)
                chk("b2b_lat", 128'(hs_q[i] - acc_q[i]), 128'd5);
        end
        in_valid = 1'b0;

        // randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_bypass = ($urandom_range(0, 3) == 0);
            in_state  = rnd128();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
